multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle control unit.
- Sequences each MIPS instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, waiting on ihit/dhit.
- Holds its own instruction register (IR) and registered ALU overflow.
- Drives datapath enables and mux selects for the shared-ALU, shared-memory datapath.

Parameters:
- ALUOP_W, 4, ALUop width. Encoding: SLL=0, SRL=1, ADD=2, SUB=3, AND=4, OR=5, XOR=6, NOR=7, SLT=8, SLTU=9.
- OVF_SUPPRESS, 1, when 1 the signed ADD/SUB/ADDI overflow suppresses the WRITEBACK RegWr.
- STATE_W, 3, width of the state debug output.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous active-high reset
- instr  in  32  memory read data, captured into IR on IRWr
- ihit  in  1  instruction memory done
- dhit  in  1  data memory done
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed overflow
- iREN  out  1  instruction read enable
- dREN  out  1  data read enable
- dWEN  out  1  data write enable
- IRWr  out  1  IR load strobe
- PCWr  out  1  PC write enable
- PCSrc  out  2  PC source: 0=PC+4, 1=branch target, 2=jump target, 3=rs (jr)
- RegWr  out  1  register file write enable
- RegDst  out  2  destination: 0=rt, 1=rd, 2=r31
- ALUSrc  out  2  ALU B operand: 0=rt, 1=extended imm, 2=shamt
- ExtOp  out  1  1=sign-extend, 0=zero-extend
- ALUop  out  ALUOP_W  ALU operation
- mem2reg  out  1  write-back data from memory
- lui  out  1  write-back data is imm<<16
- jal  out  1  write-back data is PC+4
- halt  out  1  sticky halt
- state  out  STATE_W  current state (debug)

Behaviour:
- Reset: the state register loads FETCH on a clock edge with RST=1. IR, ovf_q and halt clear to 0.
- While RST=1 all outputs are forced to 0.
- Outputs are combinational from state, IR, ihit/dhit, zero and overflow.
- All outputs are 0 unless stated below.
- FETCH(0):
  - iREN=1.
  - On ihit: IRWr=1, PCWr=1, PCSrc=0, next state DECODE.
  - Without ihit: hold FETCH indefinitely.
- DECODE(1):
  - opcode 111111 -> HALT.
  - J(000010): PCWr=1, PCSrc=2 -> FETCH.
  - JAL(000011): PCWr=1, PCSrc=2, RegWr=1, RegDst=2, jal=1 -> FETCH.
  - Any unlisted opcode or funct is a NOP -> FETCH.
  - All other opcodes -> EXECUTE.
- EXECUTE(2):
  - ALUop, ALUSrc and ExtOp decoded from the IR. Signed immediates use ExtOp=1; ANDI/ORI/XORI use ExtOp=0.
  - SLL/SRL use ALUSrc=2.
  - ovf_q <= overflow.
  - BEQ/BNE: ALUop=SUB. PCWr=(BEQ&zero)|(BNE&~zero), PCSrc=1 -> FETCH.
  - JR (funct 001000): PCWr=1, PCSrc=3 -> FETCH.
  - LW/SW: ALUop=ADD, ALUSrc=1 -> MEMORY.
  - All others -> WRITEBACK.
- MEMORY(3):
  - Hold ALU address controls. dREN=1 for LW, dWEN=1 for SW, held until dhit.
  - On dhit: SW -> FETCH, LW -> WRITEBACK.
  - dhit is ignored in all other states.
- WRITEBACK(4):
  - RegWr=1, except RegWr=0 when OVF_SUPPRESS=1, ovf_q=1 and the op is ADD/SUB/ADDI.
  - RegDst=1 for R-type, else 0. mem2reg=1 for LW; lui=1 for LUI.
  - Next state FETCH.
- HALT(5): halt=1 sticky; only RST exits.
- Each instruction takes its own IR; there is no overlap between instructions.

Optional Feature:
- Macro MCU_PERF_COUNTERS_EN.
- When defined, two ports are added:
  - instr_cnt out 32: increments on every DECODE entry except halt.
  - cycle_cnt out 32: increments every non-reset cycle while not in HALT.
  - Both counters wrap at 2^32, clear on RST, and freeze in HALT.
- When undefined, these ports and counters are absent.

Test Plan:
- Reset then ADD r3,r1,r2 (0x00221820), ihit=1 on the first FETCH cycle -> FETCH, DECODE, EXECUTE, WRITEBACK: RegWr=1, RegDst=1, ALUop=2, then back to FETCH after 4 cycles.
- LW (0x8C220004) with dhit asserted 3 cycles late -> MEMORY holds dREN=1 for 4 cycles, then WRITEBACK with mem2reg=1, RegDst=0.
- BEQ with zero=1 -> EXECUTE PCWr=1, PCSrc=1. Same instruction with zero=0 -> PCWr=0. BNE gives the inverse.
- JAL (0x0C000010) -> DECODE PCWr=1, PCSrc=2, RegWr=1, RegDst=2, jal=1; 2 cycles total.
- ADDI with overflow=1 in EXECUTE, OVF_SUPPRESS=1 -> WRITEBACK RegWr=0. With OVF_SUPPRESS=0 -> RegWr=1.
- Opcode 0xFC000000 -> halt=1 from HALT onward, stable 10+ cycles. RST mid-MEMORY (dREN=1) -> next cycle FETCH, halt=0, dREN=0. With MCU_PERF_COUNTERS_EN, instr_cnt=0 after RST.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM stepping MIPS instructions through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK; MCU_PERF_COUNTERS_EN adds instr/cycle counters
module multicycle_control_unit #(
  parameter int ALUOP_W      = 4,
  parameter int OVF_SUPPRESS = 1,
  parameter int STATE_W      = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        instr,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               zero,
  input  logic               overflow,
  output logic               iREN,
  output logic               dREN,
  output logic               dWEN,
  output logic               IRWr,
  output logic               PCWr,
  output logic [1:0]         PCSrc,
  output logic               RegWr,
  output logic [1:0]         RegDst,
  output logic [1:0]         ALUSrc,
  output logic               ExtOp,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               mem2reg,
  output logic               lui,
  output logic               jal,
  output logic               halt,
  output logic [STATE_W-1:0] state
`ifdef MCU_PERF_COUNTERS_EN
  ,
  output logic [31:0]        instr_cnt,
  output logic [31:0]        cycle_cnt
`endif
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
    S_MEMORY = 3'd3, S_WRITEBACK = 3'd4, S_HALT = 3'd5
  } state_t;
  localparam logic [ALUOP_W-1:0] A_SLL = ALUOP_W'(0), A_SRL = ALUOP_W'(1), A_ADD = ALUOP_W'(2),
    A_SUB = ALUOP_W'(3), A_AND = ALUOP_W'(4), A_OR = ALUOP_W'(5), A_XOR = ALUOP_W'(6),
    A_NOR = ALUOP_W'(7), A_SLT = ALUOP_W'(8), A_SLTU = ALUOP_W'(9);
  state_t r_state, w_next;
  logic [31:0] r_ir;
  logic r_ovf, r_halt;
  logic [5:0] w_op, w_fn;
  logic w_valid, w_extop, w_ovf_op, w_unused;
  logic [1:0] w_alusrc;
  logic [ALUOP_W-1:0] w_aluop;
  logic w_rtype, w_j, w_jal, w_beq, w_bne, w_jr, w_lw, w_sw, w_lui;
  assign w_op     = r_ir[31:26];
  assign w_fn     = r_ir[5:0];
  assign w_unused = ^r_ir[25:6];
  assign w_rtype  = w_op == 6'h00;
  assign w_j      = w_op == 6'h02;
  assign w_jal    = w_op == 6'h03;
  assign w_beq    = w_op == 6'h04;
  assign w_bne    = w_op == 6'h05;
  assign w_lui    = w_op == 6'h0f;
  assign w_lw     = w_op == 6'h23;
  assign w_sw     = w_op == 6'h2b;
  assign w_jr     = w_rtype & (w_fn == 6'h08);
  assign w_ovf_op = (w_op == 6'h08) | (w_rtype & ((w_fn == 6'h20) | (w_fn == 6'h22)));
  // instruction decode: ALU controls and legality of the opcode/funct held in IR
  always_comb begin
    w_valid  = 1'b1;
    w_aluop  = A_ADD;
    w_alusrc = 2'd1;
    w_extop  = 1'b1;
    case (w_op)
      6'h00: begin
        w_alusrc = 2'd0;
        w_extop  = 1'b0;
        case (w_fn)
          6'h00: begin w_aluop = A_SLL; w_alusrc = 2'd2; end
          6'h02: begin w_aluop = A_SRL; w_alusrc = 2'd2; end
          6'h08: w_aluop = A_SLL;
          6'h20, 6'h21: w_aluop = A_ADD;
          6'h22, 6'h23: w_aluop = A_SUB;
          6'h24: w_aluop = A_AND;
          6'h25: w_aluop = A_OR;
          6'h26: w_aluop = A_XOR;
          6'h27: w_aluop = A_NOR;
          6'h2a: w_aluop = A_SLT;
          6'h2b: w_aluop = A_SLTU;
          default: w_valid = 1'b0;
        endcase
      end
      6'h04, 6'h05: begin w_aluop = A_SUB; w_alusrc = 2'd0; end
      6'h02, 6'h03, 6'h08, 6'h09, 6'h23, 6'h2b, 6'h3f: w_valid = 1'b1;
      6'h0a: w_aluop = A_SLT;
      6'h0b: w_aluop = A_SLTU;
      6'h0c: begin w_aluop = A_AND; w_extop = 1'b0; end
      6'h0d, 6'h0f: begin w_aluop = A_OR; w_extop = 1'b0; end
      6'h0e: begin w_aluop = A_XOR; w_extop = 1'b0; end
      default: w_valid = 1'b0;
    endcase
  end
  // per-state datapath controls and next-state selection; everything is zero while RST
  always_comb begin
    {iREN, dREN, dWEN, IRWr, PCWr, RegWr, ExtOp, mem2reg, lui, jal} = '0;
    PCSrc  = 2'd0;
    RegDst = 2'd0;
    ALUSrc = 2'd0;
    ALUop  = '0;
    w_next = r_state;
    if (!RST) case (r_state)
      S_FETCH: begin
        iREN   = 1'b1;
        IRWr   = ihit;
        PCWr   = ihit;
        w_next = ihit ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        PCWr   = w_j | w_jal;
        PCSrc  = (w_j | w_jal) ? 2'd2 : 2'd0;
        RegWr  = w_jal;
        RegDst = w_jal ? 2'd2 : 2'd0;
        jal    = w_jal;
        w_next = (w_op == 6'h3f) ? S_HALT : (w_j | w_jal | ~w_valid) ? S_FETCH : S_EXECUTE;
      end
      S_EXECUTE: begin
        ALUop  = w_aluop;
        ALUSrc = w_alusrc;
        ExtOp  = w_extop;
        PCWr   = (w_beq & zero) | (w_bne & ~zero) | w_jr;
        PCSrc  = w_jr ? 2'd3 : (w_beq | w_bne) ? 2'd1 : 2'd0;
        w_next = (w_beq | w_bne | w_jr) ? S_FETCH : (w_lw | w_sw) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        ALUop  = A_ADD;
        ALUSrc = 2'd1;
        ExtOp  = 1'b1;
        dREN   = w_lw;
        dWEN   = w_sw;
        w_next = !dhit ? S_MEMORY : w_sw ? S_FETCH : S_WRITEBACK;
      end
      S_WRITEBACK: begin
        RegWr   = !((OVF_SUPPRESS != 0) && r_ovf && w_ovf_op);
        RegDst  = {1'b0, w_rtype};
        mem2reg = w_lw;
        lui     = w_lui;
        w_next  = S_FETCH;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
    halt  = r_halt & ~RST;
    state = RST ? '0 : STATE_W'(r_state);
  end
  // state, instruction register, latched overflow and sticky halt
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_ovf   <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (IRWr) r_ir <= instr;
      if (r_state == S_EXECUTE) r_ovf <= overflow;
      if (w_next == S_HALT) r_halt <= 1'b1;
    end
  end
`ifdef MCU_PERF_COUNTERS_EN
  // retired-instruction and active-cycle counters, frozen once halted
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else if (r_state != S_HALT) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (r_state == S_DECODE && w_op != 6'h3f) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed and randomized instruction streams checked against a per-instruction control model
module tb_multicycle_control_unit;
  typedef struct packed {
    logic iREN, dREN, dWEN, IRWr, PCWr;
    logic [1:0] PCSrc;
    logic RegWr;
    logic [1:0] RegDst, ALUSrc;
    logic ExtOp;
    logic [3:0] ALUop;
    logic mem2reg, lui, jal, halt;
    logic [2:0] state;
  } ctl_t;
  typedef struct {
    int kind;
    logic [3:0] alu;
    logic [1:0] src;
    bit ext, ovf, rt;
  } info_t;
  localparam int K_NOP = 0, K_ALU = 1, K_J = 2, K_JAL = 3, K_BEQ = 4, K_BNE = 5,
                 K_JR = 6, K_LW = 7, K_SW = 8, K_LUI = 9, K_HALT = 10;
  logic CLK = 1'b0, RST = 1'b1;
  logic [31:0] instr = '0;
  logic ihit = 1'b0, dhit = 1'b0, zero = 1'b0, overflow = 1'b0;
  logic iREN0, dREN0, dWEN0, IRWr0, PCWr0, RegWr0, ExtOp0, mem2reg0, lui0, jal0, halt0;
  logic iREN1, dREN1, dWEN1, IRWr1, PCWr1, RegWr1, ExtOp1, mem2reg1, lui1, jal1, halt1;
  logic [1:0] PCSrc0, RegDst0, ALUSrc0, PCSrc1, RegDst1, ALUSrc1;
  logic [3:0] ALUop0, ALUop1;
  logic [2:0] state0, state1;
  ctl_t o0, o1;
  int checks = 0, errors = 0;
  bit cur_halt = 1'b0;
`ifdef MCU_PERF_COUNTERS_EN
  logic [31:0] ic0, cc0, ic1, cc1;
  logic [31:0] n_ins = '0, n_cyc = '0;
`endif
  assign o0 = {iREN0, dREN0, dWEN0, IRWr0, PCWr0, PCSrc0, RegWr0, RegDst0, ALUSrc0, ExtOp0, ALUop0, mem2reg0, lui0, jal0, halt0, state0};
  assign o1 = {iREN1, dREN1, dWEN1, IRWr1, PCWr1, PCSrc1, RegWr1, RegDst1, ALUSrc1, ExtOp1, ALUop1, mem2reg1, lui1, jal1, halt1, state1};
  always #5 CLK = ~CLK;
  multicycle_control_unit u0 (
    .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero), .overflow(overflow),
    .iREN(iREN0), .dREN(dREN0), .dWEN(dWEN0), .IRWr(IRWr0), .PCWr(PCWr0), .PCSrc(PCSrc0),
    .RegWr(RegWr0), .RegDst(RegDst0), .ALUSrc(ALUSrc0), .ExtOp(ExtOp0), .ALUop(ALUop0),
    .mem2reg(mem2reg0), .lui(lui0), .jal(jal0), .halt(halt0), .state(state0)
`ifdef MCU_PERF_COUNTERS_EN
    , .instr_cnt(ic0), .cycle_cnt(cc0)
`endif
  );
  multicycle_control_unit #(.OVF_SUPPRESS(0)) u1 (
    .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero), .overflow(overflow),
    .iREN(iREN1), .dREN(dREN1), .dWEN(dWEN1), .IRWr(IRWr1), .PCWr(PCWr1), .PCSrc(PCSrc1),
    .RegWr(RegWr1), .RegDst(RegDst1), .ALUSrc(ALUSrc1), .ExtOp(ExtOp1), .ALUop(ALUop1),
    .mem2reg(mem2reg1), .lui(lui1), .jal(jal1), .halt(halt1), .state(state1)
`ifdef MCU_PERF_COUNTERS_EN
    , .instr_cnt(ic1), .cycle_cnt(cc1)
`endif
  );
  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic info_t lookup(input logic [31:0] w);
    info_t d;
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    d.kind = K_NOP; d.alu = 4'd0; d.src = 2'd0; d.ext = 1'b0; d.ovf = 1'b0; d.rt = (op == 6'd0);
    if (op == 6'd0) begin
      if (fn == 6'h08) d.kind = K_JR;
      else if (fn == 6'h00 || fn == 6'h02) begin d.kind = K_ALU; d.alu = (fn == 6'h00) ? 4'd0 : 4'd1; d.src = 2'd2; end
      else if (fn >= 6'h20 && fn <= 6'h27) begin
        d.kind = K_ALU;
        d.alu = (fn <= 6'h23) ? 4'(2 + ((fn - 6'h20) >> 1)) : 4'(fn - 6'h20);
        d.ovf = (fn == 6'h20 || fn == 6'h22);
      end
      else if (fn == 6'h2a || fn == 6'h2b) begin d.kind = K_ALU; d.alu = 4'(8 + fn - 6'h2a); end
    end else case (op)
      6'h02: d.kind = K_J;
      6'h03: d.kind = K_JAL;
      6'h3f: d.kind = K_HALT;
      6'h04, 6'h05: begin d.kind = (op == 6'h04) ? K_BEQ : K_BNE; d.alu = 4'd3; d.ext = 1'b1; end
      6'h23, 6'h2b: begin d.kind = (op == 6'h23) ? K_LW : K_SW; d.alu = 4'd2; d.src = 2'd1; d.ext = 1'b1; end
      6'h08: begin d.kind = K_ALU; d.alu = 4'd2; d.src = 2'd1; d.ext = 1'b1; d.ovf = 1'b1; end
      6'h09: begin d.kind = K_ALU; d.alu = 4'd2; d.src = 2'd1; d.ext = 1'b1; end
      6'h0a: begin d.kind = K_ALU; d.alu = 4'd8; d.src = 2'd1; d.ext = 1'b1; end
      6'h0b: begin d.kind = K_ALU; d.alu = 4'd9; d.src = 2'd1; d.ext = 1'b1; end
      6'h0c: begin d.kind = K_ALU; d.alu = 4'd4; d.src = 2'd1; end
      6'h0d: begin d.kind = K_ALU; d.alu = 4'd5; d.src = 2'd1; end
      6'h0e: begin d.kind = K_ALU; d.alu = 4'd6; d.src = 2'd1; end
      6'h0f: begin d.kind = K_LUI; d.alu = 4'd5; d.src = 2'd1; end
      default: d.kind = K_NOP;
    endcase
    return d;
  endfunction
  task automatic step(input bit rs, ih, dh, z, ov, input logic [31:0] iw, input ctl_t e0, e1, input string tag);
    @(negedge CLK);
    RST = rs; ihit = ih; dhit = dh; zero = z; overflow = ov; instr = iw;
    #1;
    checks++;
    assert (o0 === e0) else begin errors++; $error("FAIL %s u0 observed=%h expected=%h", tag, o0, e0); end
    checks++;
    assert (o1 === e1) else begin errors++; $error("FAIL %s u1 observed=%h expected=%h", tag, o1, e1); end
`ifdef MCU_PERF_COUNTERS_EN
    checks++;
    assert ({ic0, cc0} === {n_ins, n_cyc}) else begin errors++; $error("FAIL %s counters observed=%h/%h expected=%h/%h", tag, ic0, cc0, n_ins, n_cyc); end
    if (rs) begin n_ins = '0; n_cyc = '0; end
    else begin
      if (e0.state != 3'd5) n_cyc++;
      if (e0.state == 3'd1 && !cur_halt) n_ins++;
    end
`endif
  endtask
  task automatic run_instr(input logic [31:0] ins, input int fw, mw, input bit z, ov, abort);
    ctl_t e, e1;
    info_t d;
    d = lookup(ins);
    cur_halt = (d.kind == K_HALT);
    for (int k = 0; k <= fw; k++) begin
      e = '0; e.iREN = 1'b1; e.IRWr = (k == fw); e.PCWr = (k == fw);
      step(1'b0, k == fw, rb(), rb(), rb(), (k == fw) ? ins : $urandom, e, e, "fetch");
    end
    e = '0; e.state = 3'd1;
    if (d.kind == K_J || d.kind == K_JAL) begin e.PCWr = 1'b1; e.PCSrc = 2'd2; end
    if (d.kind == K_JAL) begin e.RegWr = 1'b1; e.RegDst = 2'd2; e.jal = 1'b1; end
    step(1'b0, rb(), rb(), rb(), rb(), $urandom, e, e, "decode");
    if (d.kind == K_HALT)
      for (int k = 0; k < 12; k++) begin
        e = '0; e.halt = 1'b1; e.state = 3'd5;
        step(1'b0, rb(), rb(), rb(), rb(), $urandom, e, e, "halt");
      end
    if (d.kind inside {K_HALT, K_J, K_JAL, K_NOP}) return;
    e = '0; e.state = 3'd2; e.ALUop = d.alu; e.ALUSrc = d.src; e.ExtOp = d.ext;
    if (d.kind == K_BEQ) begin e.PCWr = z; e.PCSrc = 2'd1; end
    if (d.kind == K_BNE) begin e.PCWr = !z; e.PCSrc = 2'd1; end
    if (d.kind == K_JR) begin e.PCWr = 1'b1; e.PCSrc = 2'd3; end
    step(1'b0, rb(), rb(), z, ov, $urandom, e, e, "execute");
    if (d.kind inside {K_BEQ, K_BNE, K_JR}) return;
    if (d.kind == K_LW || d.kind == K_SW) begin
      for (int k = 0; k <= mw; k++) begin
        e = '0; e.state = 3'd3; e.ALUop = 4'd2; e.ALUSrc = 2'd1; e.ExtOp = 1'b1;
        e.dREN = (d.kind == K_LW); e.dWEN = (d.kind == K_SW);
        step(1'b0, rb(), (k == mw) && !abort, rb(), rb(), $urandom, e, e, "memory");
        if (abort) begin
          e = '0;
          step(1'b1, rb(), rb(), rb(), rb(), $urandom, e, e, "rst_in_memory");
          return;
        end
      end
      if (d.kind == K_SW) return;
    end
    e = '0; e.state = 3'd4; e.RegWr = 1'b1; e.RegDst = {1'b0, d.rt};
    e.mem2reg = (d.kind == K_LW); e.lui = (d.kind == K_LUI);
    e1 = e;
    if (ov && d.ovf) e.RegWr = 1'b0;
    step(1'b0, rb(), rb(), rb(), rb(), $urandom, e, e1, "writeback");
  endtask
  initial begin
    logic [5:0] ops [20];
    logic [31:0] r;
    ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
            6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h3e, 6'h11, 6'h00};
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00221820, '0, '0, "reset0");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00221820, '0, '0, "reset1");
    run_instr(32'h00221820, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h8C220004, 1, 3, 1'b0, 1'b0, 1'b0);
    run_instr(32'hAC220008, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h10220003, 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr(32'h10220003, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h14220003, 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr(32'h14220003, 2, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h0C000010, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h08000010, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h03E00008, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h20220005, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr(32'h20220005, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h00221820, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr(32'h00221822, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr(32'h00221821, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr(32'h34220FFF, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h3C011234, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h00011080, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h00011082, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h0022182A, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h00221827, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'hF8000000, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h00000001, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      run_instr({ops[$urandom_range(0, 19)], r[25:0]}, $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb(), 1'b0);
    end
    run_instr(32'hFC000000, 1, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, rb(), rb(), rb(), rb(), $urandom, '0, '0, "rst_from_halt");
    run_instr(32'h00221820, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h8C220004, 0, 2, 1'b0, 1'b0, 1'b1);
    run_instr(32'h00221820, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h8C220004, 0, 0, 1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
